// File: rtl/parking_pkg.sv
// Shared constants for the parking lot counter: active-low seven-segment
// glyphs ({g,f,e,d,c,b,a}) and the capacity ceiling the display can show.
package parking_pkg;

    localparam int MAX_CAPACITY = 99;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_r     = 7'b0101111;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_U     = 7'b1000001;

endpackage

// File: rtl/seg7_decode.sv
// Decimal digit to active-low seven-segment pattern; codes 10..15 go blank.
module seg7_decode
    import parking_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/parking_occupancy_counter.sv
// Saturating occupancy counter fed by entrance/exit pulses, with sticky
// bound-violation flags and a registered six-digit seven-segment display.
module parking_occupancy_counter
    import parking_pkg::*;
#(
    parameter int CAPACITY = 25,
    parameter int CNT_W    = $clog2(CAPACITY + 1)
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             incr,
    input  logic             decr,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX3,
    output logic [6:0]       HEX4,
    output logic [6:0]       HEX5
);

    localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);
    localparam logic [5:0][6:0] DISP_EMPTY = {SEG_C, SEG_L, SEG_E, SEG_A, SEG_r, SEG_0};

    logic             incr_q, decr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic [5:0][6:0]  hex_q, hex_d;
    logic             inc_ev, dec_ev;
    logic [6:0]       cnt7;
    logic [3:0]       tens, ones;
    logic [6:0]       tens_seg, ones_seg;

    assign inc_ev = incr & ~incr_q;
    assign dec_ev = decr & ~decr_q;
    assign full   = (count_q == CAP);
    assign empty  = (count_q == '0);

    // Simultaneous entry and exit cancel: no movement and no flag.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (inc_ev && !dec_ev) begin
            if (count_q != CAP) count_d = count_q + 1'b1;
            else                ovf_d   = 1'b1;
        end else if (dec_ev && !inc_ev) begin
            if (count_q != '0)  count_d = count_q - 1'b1;
            else                unf_d   = 1'b1;
        end
    end

    assign cnt7 = 7'(count_q);
    assign tens = 4'(cnt7 / 7'd10);
    assign ones = 4'(cnt7 % 7'd10);

    seg7_decode u_tens (.digit_i(tens), .seg_o(tens_seg));
    seg7_decode u_ones (.digit_i(ones), .seg_o(ones_seg));

    always_comb begin
        hex_d = DISP_EMPTY;
        if (empty)
            hex_d = DISP_EMPTY;
        else if (full)
            hex_d = {SEG_F, SEG_U, SEG_L, SEG_L, tens_seg, ones_seg};
        else
            hex_d = {SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
                     (tens == 4'd0) ? SEG_BLANK : tens_seg, ones_seg};
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            incr_q  <= 1'b0;
            decr_q  <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            hex_q   <= DISP_EMPTY;
        end else begin
            incr_q  <= incr;
            decr_q  <= decr;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            hex_q   <= hex_d;
        end
    end

    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign HEX0      = hex_q[0];
    assign HEX1      = hex_q[1];
    assign HEX2      = hex_q[2];
    assign HEX3      = hex_q[3];
    assign HEX4      = hex_q[4];
    assign HEX5      = hex_q[5];

endmodule

// File: tb/tb_parking_occupancy_counter.sv
// Directed bench for the parking occupancy counter: an event-level model is
// compared every cycle, plus hand-computed literal checkpoints.
module tb_parking_occupancy_counter;

    localparam int CAP = 25;

    logic       CLOCK_50 = 1'b0;
    logic       reset, incr, decr;
    logic [4:0] count;
    logic       full, empty, overflow, underflow;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    int total = 0;
    int bad   = 0;

    parking_occupancy_counter #(.CAPACITY(CAP)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .incr(incr), .decr(decr),
        .count(count), .full(full), .empty(empty),
        .overflow(overflow), .underflow(underflow),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
    );

    initial forever #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;  1: return 7'b1111001;
            2: return 7'b0100100;  3: return 7'b0110000;
            4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;
            8: return 7'b0000000;  9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Display content as a function of the occupancy it shows.
    function automatic logic [41:0] exp_hex(input int c);
        logic [6:0] bl;
        bl = 7'b1111111;
        if (c == 0)
            return {7'b1000110, 7'b1000111, 7'b0000110, 7'b0001000, 7'b0101111, 7'b1000000};
        else if (c == CAP)
            return {7'b0001110, 7'b1000001, 7'b1000111, 7'b1000111, seg(c / 10), seg(c % 10)};
        else
            return {bl, bl, bl, bl, (c / 10 == 0) ? bl : seg(c / 10), seg(c % 10)};
    endfunction

    // Event-level model: occupancy, sticky flags and the count the display shows.
    int m_cnt, m_hexc;
    bit m_ovf, m_unf, p_inc, p_dec, chk_en;

    always @(posedge CLOCK_50) begin : mdl
        bit ie, de;
        if (reset) begin
            m_cnt = 0; m_hexc = 0; m_ovf = 0; m_unf = 0; p_inc = 0; p_dec = 0;
        end else begin
            ie = incr && !p_inc;
            de = decr && !p_dec;
            m_hexc = m_cnt;
            if (ie && !de) begin
                if (m_cnt == CAP) m_ovf = 1; else m_cnt++;
            end else if (de && !ie) begin
                if (m_cnt == 0) m_unf = 1; else m_cnt--;
            end
            p_inc = incr;
            p_dec = decr;
        end
    end

    always @(negedge CLOCK_50) begin
        if (chk_en) begin
            chk("count", count, m_cnt);
            chk("full", full, m_cnt == CAP);
            chk("empty", empty, m_cnt == 0);
            chk("overflow", overflow, m_ovf);
            chk("underflow", underflow, m_unf);
            chk("hex", {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, exp_hex(m_hexc));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic pulse_inc();
        incr = 1'b1; tick(1); incr = 1'b0; tick(1);
    endtask

    task automatic pulse_dec();
        decr = 1'b1; tick(1); decr = 1'b0; tick(1);
    endtask

    task automatic lit_hex(input string nm, input logic [6:0] e5, e4, e3, e2, e1, e0);
        chk(nm, {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {e5, e4, e3, e2, e1, e0});
    endtask

    initial begin
        chk_en = 0;
        reset = 1'b1; incr = 1'b0; decr = 1'b0;
        tick(2);
        reset = 1'b0;
        chk_en = 1;
        chk("lit_rst_count", count, 0);
        chk("lit_rst_empty", empty, 1);
        chk("lit_rst_full", full, 0);
        chk("lit_rst_flags", {overflow, underflow}, 0);
        lit_hex("lit_rst_hex", 7'b1000110, 7'b1000111, 7'b0000110, 7'b0001000, 7'b0101111, 7'b1000000);

        // Held level counts once
        incr = 1'b1; tick(1);
        chk("lit_held_count1", count, 1);
        tick(4);
        chk("lit_held_count5", count, 1);
        incr = 1'b0;
        lit_hex("lit_held_hex", 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111001);
        tick(1);

        repeat (24) pulse_inc();
        chk("lit_fill_count", count, 25);
        chk("lit_fill_full", full, 1);
        lit_hex("lit_fill_hex", 7'b0001110, 7'b1000001, 7'b1000111, 7'b1000111, 7'b0100100, 7'b0010010);
        pulse_inc();
        chk("lit_ovf_count", count, 25);
        chk("lit_ovf_flag", overflow, 1);

        repeat (25) pulse_dec();
        chk("lit_drain_count", count, 0);
        chk("lit_drain_empty", empty, 1);
        lit_hex("lit_drain_hex", 7'b1000110, 7'b1000111, 7'b0000110, 7'b0001000, 7'b0101111, 7'b1000000);
        pulse_dec();
        chk("lit_unf_flags", {overflow, underflow}, 2'b11);
        chk("lit_unf_count", count, 0);

        reset = 1'b1; tick(1); reset = 1'b0;
        chk("lit_clr_flags", {overflow, underflow}, 0);
        repeat (12) pulse_inc();
        lit_hex("lit_12_hex", 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111001, 7'b0100100);

        // Both rise together, then entry while exit level stays high
        incr = 1'b1; decr = 1'b1; tick(1);
        chk("lit_sim_count", count, 12);
        chk("lit_sim_flags", {overflow, underflow}, 0);
        incr = 1'b0; tick(1);
        incr = 1'b1; tick(1);
        chk("lit_inc_dechigh", count, 13);
        incr = 1'b0; decr = 1'b0; tick(2);

        // Reset beats a same-cycle rising incr
        reset = 1'b1; incr = 1'b1; tick(1);
        reset = 1'b0;
        chk("lit_rstinc_count", count, 0);
        chk("lit_rstinc_flags", {overflow, underflow}, 0);
        tick(1);
        incr = 1'b0; tick(3);

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
